// File: rtl/ifetch_queue_if.sv
// Instruction fetch queue bus: SRAM read port, execute redirect and decode handshake.
// master = fetch queue side, slave = SRAM/pipeline environment side.
interface ifetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   im_dataout;
   logic          im_cs;
   logic          im_oe;
   logic [3:0]    im_web;
   logic [13:0]   im_addr;
   logic [31:0]   im_datain;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          deq_ready;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [31:0]   inst_pc;
   logic [CW-1:0] count;

   modport master (
      input  im_dataout,
      input  redirect_valid,
      input  redirect_pc,
      input  deq_ready,
      output im_cs,
      output im_oe,
      output im_web,
      output im_addr,
      output im_datain,
      output inst_valid,
      output inst,
      output inst_pc,
      output count
   );

   modport slave (
      output im_dataout,
      output redirect_valid,
      output redirect_pc,
      output deq_ready,
      input  im_cs,
      input  im_oe,
      input  im_web,
      input  im_addr,
      input  im_datain,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      input  count
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: prefetches sequential words from a 1-cycle SRAM
// into a small circular buffer, flushed by execute-stage redirects.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   ifetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   pc_q   [DEPTH];

   logic [CW-1:0] credit;
   logic          issue;
   logic          enq;
   logic          deq;

   // Credit counts the inflight read so a returning word always has a free slot.
   always_comb begin
      credit = cnt_q + CW'(inflight_q);
      issue  = rst && !bus.redirect_valid && (credit < CW'(DEPTH));
      enq    = inflight_q && !bus.redirect_valid;
      deq    = (cnt_q != '0) && bus.deq_ready;

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      cnt_d         = cnt_q;

      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & ~32'h3;
         wptr_d     = '0;
         rptr_d     = '0;
         cnt_d      = '0;
      end else begin
         if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (enq) wptr_d = wptr_q + 1'b1;
         if (deq) rptr_d = rptr_q + 1'b1;
         case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         cnt_q         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         cnt_q         <= cnt_d;
         if (enq) begin
            inst_q[wptr_q] <= bus.im_dataout;
            pc_q[wptr_q]   <= inflight_pc_q;
         end
      end
   end

   assign bus.im_cs      = issue;
   assign bus.im_oe      = 1'b1;
   assign bus.im_web     = 4'b1111;
   assign bus.im_addr    = fetch_pc_q[15:2];
   assign bus.im_datain  = '0;
   assign bus.inst_valid = (cnt_q != '0);
   assign bus.inst       = inst_q[rptr_q];
   assign bus.inst_pc    = pc_q[rptr_q];
   assign bus.count      = cnt_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: cycle table plus redirect, wrap and reset sequences.
// The SRAM model returns word N at word address N, one cycle after a read.
module tb_ifetch_queue;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ifetch_queue_if #(.DEPTH(4)) bus ();

   ifetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.im_cs) bus.im_dataout <= {18'h0, bus.im_addr};

   typedef struct {
      logic        deq;
      logic        rv;
      logic [31:0] rpc;
      logic        cs;
      logic [13:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tab [22];

   function automatic vec_t mk(bit d, bit r, int rpc, bit cs, int addr,
                               bit v, int pc, int ins, int cnt);
      vec_t t;
      t.deq  = d;
      t.rv   = r;
      t.rpc  = 32'(rpc);
      t.cs   = cs;
      t.addr = 14'(addr);
      t.vld  = v;
      t.pc   = 32'(pc);
      t.ins  = 32'(ins);
      t.cnt  = 3'(cnt);
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.deq_ready = 1'b0;

      tab[0]  = mk(0, 0, 0,     1, 'h00, 0, 0,     0,     0);
      tab[1]  = mk(0, 0, 0,     1, 'h01, 0, 0,     0,     0);
      tab[2]  = mk(0, 0, 0,     1, 'h02, 1, 0,     0,     1);
      tab[3]  = mk(0, 0, 0,     1, 'h03, 1, 0,     0,     2);
      tab[4]  = mk(0, 0, 0,     0, 'h04, 1, 0,     0,     3);
      tab[5]  = mk(0, 0, 0,     0, 'h04, 1, 0,     0,     4);
      tab[6]  = mk(0, 0, 0,     0, 'h04, 1, 0,     0,     4);
      tab[7]  = mk(1, 0, 0,     0, 'h04, 1, 0,     0,     4);
      tab[8]  = mk(1, 0, 0,     1, 'h04, 1, 'h4,   1,     3);
      tab[9]  = mk(1, 0, 0,     1, 'h05, 1, 'h8,   2,     2);
      tab[10] = mk(1, 0, 0,     1, 'h06, 1, 'hC,   3,     2);
      tab[11] = mk(0, 0, 0,     1, 'h07, 1, 'h10,  4,     2);
      tab[12] = mk(0, 1, 'h103, 0, 'h08, 1, 'h10,  4,     3);
      tab[13] = mk(1, 0, 0,     1, 'h40, 0, 0,     0,     0);
      tab[14] = mk(1, 0, 0,     1, 'h41, 0, 0,     0,     0);
      tab[15] = mk(1, 0, 0,     1, 'h42, 1, 'h100, 'h40,  1);
      tab[16] = mk(1, 0, 0,     1, 'h43, 1, 'h104, 'h41,  1);
      tab[17] = mk(1, 1, 'h200, 0, 'h44, 1, 'h108, 'h42,  1);
      tab[18] = mk(1, 1, 'h307, 0, 'h80, 0, 0,     0,     0);
      tab[19] = mk(1, 0, 0,     1, 'hC1, 0, 0,     0,     0);
      tab[20] = mk(1, 0, 0,     1, 'hC2, 0, 0,     0,     0);
      tab[21] = mk(1, 0, 0,     1, 'hC3, 1, 'h304, 'hC1,  1);

      // Reset state
      repeat (2) step();
      chk("rst_cs",     32'(bus.im_cs),      32'h0);
      chk("rst_oe",     32'(bus.im_oe),      32'h1);
      chk("rst_web",    32'(bus.im_web),     32'hF);
      chk("rst_datain", bus.im_datain,       32'h0);
      chk("rst_addr",   32'(bus.im_addr),    32'h0);
      chk("rst_valid",  32'(bus.inst_valid), 32'h0);
      chk("rst_count",  32'(bus.count),      32'h0);
      chk("rst_inst",   bus.inst,            32'h0);
      chk("rst_pc",     bus.inst_pc,         32'h0);

      rst = 1'b1;
      for (int i = 0; i < 22; i++) begin
         bus.deq_ready      = tab[i].deq;
         bus.redirect_valid = tab[i].rv;
         bus.redirect_pc    = tab[i].rpc;
         #1;
         chk($sformatf("t%0d_cs", i),    32'(bus.im_cs),      32'(tab[i].cs));
         chk($sformatf("t%0d_addr", i),  32'(bus.im_addr),    32'(tab[i].addr));
         chk($sformatf("t%0d_valid", i), 32'(bus.inst_valid), 32'(tab[i].vld));
         chk($sformatf("t%0d_count", i), 32'(bus.count),      32'(tab[i].cnt));
         if (tab[i].vld) begin
            chk($sformatf("t%0d_pc", i),   bus.inst_pc, tab[i].pc);
            chk($sformatf("t%0d_inst", i), bus.inst,    tab[i].ins);
         end
         step();
      end

      // Random decode back-pressure: FIFO order must hold
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_1000;
      step();
      bus.redirect_valid = 1'b0;
      exp_pc = 32'h0000_1000;
      for (int i = 0; i < 30; i++) begin
         bus.deq_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_bound", 32'(bus.count <= 3'd4), 32'h1);
         if (bus.inst_valid && bus.deq_ready) begin
            chk("rnd_pc",   bus.inst_pc, exp_pc);
            chk("rnd_inst", bus.inst,    {18'h0, exp_pc[15:2]});
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      chk("rnd_progress", 32'(exp_pc > 32'h0000_1000), 32'h1);

      // Fetch address wrap at the top of the address space
      bus.deq_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      #1;
      chk("wrap_cs0",   32'(bus.im_cs),   32'h1);
      chk("wrap_addr0", 32'(bus.im_addr), 32'h3FFF);
      step();
      #1;
      chk("wrap_addr1", 32'(bus.im_addr), 32'h0);
      step();
      #1;
      chk("wrap_valid", 32'(bus.inst_valid), 32'h1);
      chk("wrap_pc0",   bus.inst_pc,         32'hFFFF_FFFC);
      chk("wrap_inst0", bus.inst,            32'h0000_3FFF);
      step();
      #1;
      chk("wrap_pc1",   bus.inst_pc, 32'h0);
      chk("wrap_inst1", bus.inst,    32'h0);
      step();

      // Half-cycle reset pulse between clock edges
      #1;
      chk("pulse_pre_valid", 32'(bus.inst_valid), 32'h1);
      rst = 1'b0;
      #1;
      chk("pulse_valid", 32'(bus.inst_valid), 32'h0);
      chk("pulse_count", 32'(bus.count),      32'h0);
      chk("pulse_cs",    32'(bus.im_cs),      32'h0);
      chk("pulse_pc",    bus.inst_pc,         32'h0);
      chk("pulse_addr",  32'(bus.im_addr),    32'h0);
      #1;
      rst = 1'b1;
      #1;
      chk("rel_cs",   32'(bus.im_cs),   32'h1);
      chk("rel_addr", 32'(bus.im_addr), 32'h0);
      step();
      #1;
      chk("rel_addr1", 32'(bus.im_addr),    32'h1);
      chk("rel_valid", 32'(bus.inst_valid), 32'h0);
      step();
      #1;
      chk("rel_valid2", 32'(bus.inst_valid), 32'h1);
      chk("rel_pc",     bus.inst_pc,         32'h0);
      chk("rel_addr2",  32'(bus.im_addr),    32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
